// File: rtl/spi_regfile.sv
// SPI mode-0 peripheral giving a host read/write access to NUM_REGS x DATA_W registers; inputs oversampled on clk.
// Optional rejected-frame status register at address NUM_REGS is enabled by defining SPI_REGFILE_STATUS_EN.
module spi_regfile #(
  parameter int                NUM_REGS  = 5,
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 7,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sclk,
  input  logic                       ncs,
  input  logic                       copi,
  output logic                       cipo,
  output logic                       cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_strobe
);
  localparam int FRAME = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME + 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          sclk_sync_q, sclk_sync_d;
  logic [2:0]          ncs_sync_q, ncs_sync_d;
  logic [1:0]          copi_sync_q, copi_sync_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rw_q, rw_d;
  logic                ovr_q, ovr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   addr_shift;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   rd_word;
  logic                cipo_q, cipo_d;
  logic                cipo_oe_q, cipo_oe_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_strobe_q, wr_strobe_d;
  logic                sclk_rise, sclk_fall, ncs_rise, ncs_fall, copi_s;
  logic                frame_end, valid_len;

  assign sclk_sync_d = {sclk_sync_q[1:0], sclk};
  assign ncs_sync_d  = {ncs_sync_q[1:0], ncs};
  assign copi_sync_d = {copi_sync_q[0], copi};
  assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign ncs_rise    = ncs_sync_q[1] & ~ncs_sync_q[2];
  assign ncs_fall    = ~ncs_sync_q[1] & ncs_sync_q[2];
  assign copi_s      = copi_sync_q[1];
  assign addr_shift  = (addr_q << 1) | ADDR_W'(copi_s);
  assign valid_len   = (cnt_q == CNT_W'(FRAME)) && !ovr_q;

`ifdef SPI_REGFILE_STATUS_EN
  logic [DATA_W-1:0] rej_cnt_q, rej_cnt_d;

  always_comb begin
    rej_cnt_d = rej_cnt_q;
    if (frame_end) begin
      if (!valid_len || (rw_q && addr_q > ADDR_W'(NUM_REGS))) begin
        if (rej_cnt_q != '1) rej_cnt_d = rej_cnt_q + DATA_W'(1);
      end else if (rw_q && addr_q == ADDR_W'(NUM_REGS)) begin
        rej_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rej_cnt_q <= '0;
    else     rej_cnt_q <= rej_cnt_d;
  end
`endif

  // Read word for the full address formed on the last address-bit edge.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_shift == ADDR_W'(i)) rd_word = regs_q[i];
    end
`ifdef SPI_REGFILE_STATUS_EN
    if (addr_shift == ADDR_W'(NUM_REGS)) rd_word = rej_cnt_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    ovr_d     = ovr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cipo_d    = cipo_q;
    frame_end = 1'b0;
    if (ncs_fall) begin
      // New frame, or abort of an unfinished one: nothing is committed.
      state_d = S_CMD;
      cnt_d   = '0;
      rw_d    = 1'b0;
      ovr_d   = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      rdata_d = '0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_DONE: state_d = S_IDLE;
        default: begin
          if (ncs_rise) begin
            frame_end = 1'b1;
            state_d   = S_DONE;
          end else if (sclk_rise) begin
            if (cnt_q == CNT_W'(FRAME)) ovr_d = 1'b1;
            else                        cnt_d = cnt_q + CNT_W'(1);
            case (state_q)
              S_CMD: begin
                rw_d    = copi_s;
                state_d = S_ADDR;
              end
              S_ADDR: begin
                addr_d = addr_shift;
                if (cnt_q == CNT_W'(ADDR_W)) begin
                  rdata_d = rd_word;
                  state_d = S_DATA;
                end
              end
              S_DATA: if (rw_q) wdata_d = (wdata_q << 1) | DATA_W'(copi_s);
              default: ;
            endcase
          end else if (sclk_fall && state_q == S_DATA && !rw_q) begin
            cipo_d  = rdata_q[DATA_W-1];
            rdata_d = rdata_q << 1;
          end
        end
      endcase
    end
    cipo_oe_d = (state_d == S_DATA) && !rw_d;
    if (!cipo_oe_d) cipo_d = 1'b0;
  end

  always_comb begin
    regs_d      = regs_q;
    wr_strobe_d = '0;
    if (frame_end && valid_len && rw_q) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (addr_q == ADDR_W'(i)) begin
          regs_d[i]      = wdata_q;
          wr_strobe_d[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sclk_sync_q <= '0;
      ncs_sync_q  <= '1;
      copi_sync_q <= '0;
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      ovr_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
      wr_strobe_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      ncs_sync_q  <= ncs_sync_d;
      copi_sync_q <= copi_sync_d;
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      ovr_q       <= ovr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cipo_q      <= cipo_d;
      cipo_oe_q   <= cipo_oe_d;
      wr_strobe_q <= wr_strobe_d;
      regs_q      <= regs_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign cipo      = cipo_q;
  assign cipo_oe   = cipo_oe_q;
  assign wr_strobe = wr_strobe_q;
endmodule

// File: tb/tb_spi_regfile.sv
// Bench for spi_regfile: directed vector table, hand-written reset/back-to-back/idle-sclk sequences,
// then random frames checked against an array-based model of the register bank and reject counter.
module tb_spi_regfile;
  localparam int NR = 5;
  localparam int DW = 8;
  localparam int AW = 7;
  localparam int HALF = 50;
`ifdef SPI_REGFILE_STATUS_EN
  localparam bit STATUS = 1'b1;
`else
  localparam bit STATUS = 1'b0;
`endif

  logic clk, rst, sclk, ncs, copi;
  logic cipo, cipo_oe;
  logic [NR*DW-1:0] regs_flat;
  logic [NR-1:0] wr_strobe;

  int total = 0;
  int bad = 0;

  spi_regfile #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs_flat(regs_flat), .wr_strobe(wr_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0] stb_log [$];
  always @(negedge clk) if (wr_strobe != '0) stb_log.push_back(wr_strobe);

  logic [DW-1:0] m_regs [NR];
  int m_rej;

  function automatic logic [NR*DW-1:0] m_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = m_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_rej = 0;
  endtask

  task automatic model_frame(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input int nbits, output logic [NR-1:0] exp_stb, output logic [DW-1:0] exp_rd);
    exp_stb = '0;
    if (addr < NR) exp_rd = m_regs[addr];
    else if (STATUS && addr == NR) exp_rd = DW'(m_rej);
    else exp_rd = '0;
    if (nbits != 1 + AW + DW) begin
      if (m_rej < 255) m_rej++;
    end else if (rw) begin
      if (addr < NR) begin
        m_regs[addr] = data;
        exp_stb[addr] = 1'b1;
      end else if (addr == NR) m_rej = 0;
      else if (m_rej < 255) m_rej++;
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one frame of nbits; returns the 8 bits read on data-bit rising edges and oe mismatches.
  task automatic spi_xfer(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int nbits, output logic [DW-1:0] rd, output int oe_err);
    logic [17:0] w;
    w = {rw, addr, data, 2'b00};
    rd = '0;
    oe_err = 0;
    ncs = 1'b0;
    #HALF;
    for (int i = 0; i < nbits; i++) begin
      copi = w[17-i];
      #HALF sclk = 1'b1;
      if (cipo_oe !== (!rw && i >= 1 + AW)) oe_err++;
      if (i >= 1 + AW && i < 1 + AW + DW) rd = {rd[DW-2:0], cipo};
      #HALF sclk = 1'b0;
    end
    #HALF ncs = 1'b1;
    copi = 1'b0;
    #40;
  endtask

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            nbits;
    logic [NR*DW-1:0] exp_regs;
    logic [NR-1:0] exp_stb;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs [11];
  logic [NR-1:0] m_stb;
  logic [DW-1:0] m_rd, rd;
  int oe_err;

  initial begin
    vecs[0]  = '{1'b1, 7'h02, 8'hA5, 16, 40'h00_00_A5_00_00, 5'b00100, 8'h00};
    vecs[1]  = '{1'b1, 7'h04, 8'h3C, 16, 40'h3C_00_A5_00_00, 5'b10000, 8'h00};
    vecs[2]  = '{1'b0, 7'h04, 8'h00, 16, 40'h3C_00_A5_00_00, 5'b00000, 8'h3C};
    vecs[3]  = '{1'b1, 7'h01, 8'h77, 12, 40'h3C_00_A5_00_00, 5'b00000, 8'h00};
    vecs[4]  = '{1'b1, 7'h01, 8'h66, 17, 40'h3C_00_A5_00_00, 5'b00000, 8'h00};
    vecs[5]  = '{1'b0, 7'h05, 8'h00, 16, 40'h3C_00_A5_00_00, 5'b00000, STATUS ? 8'h02 : 8'h00};
    vecs[6]  = '{1'b1, 7'h7F, 8'hFF, 16, 40'h3C_00_A5_00_00, 5'b00000, 8'h00};
    vecs[7]  = '{1'b0, 7'h7F, 8'h00, 16, 40'h3C_00_A5_00_00, 5'b00000, 8'h00};
    vecs[8]  = '{1'b0, 7'h02, 8'h00, 16, 40'h3C_00_A5_00_00, 5'b00000, 8'hA5};
    vecs[9]  = '{1'b1, 7'h05, 8'h00, 16, 40'h3C_00_A5_00_00, 5'b00000, 8'h00};
    vecs[10] = '{1'b0, 7'h05, 8'h00, 16, 40'h3C_00_A5_00_00, 5'b00000, 8'h00};

    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    model_reset();
    #40;
    check("reset regs", regs_flat, '0);
    check("reset cipo", cipo, 1'b0);
    check("reset cipo_oe", cipo_oe, 1'b0);
    check("reset strobe", wr_strobe, '0);
    rst = 1'b0;
    #50;

    for (int k = 0; k < 11; k++) begin
      stb_log.delete();
      model_frame(vecs[k].rw, vecs[k].addr, vecs[k].data, vecs[k].nbits, m_stb, m_rd);
      spi_xfer(vecs[k].rw, vecs[k].addr, vecs[k].data, vecs[k].nbits, rd, oe_err);
      check($sformatf("vec%0d regs", k), regs_flat, vecs[k].exp_regs);
      #60;
      check($sformatf("vec%0d strobe pulses", k), stb_log.size(), (vecs[k].exp_stb != '0) ? 1 : 0);
      if (stb_log.size() > 0) check($sformatf("vec%0d strobe", k), stb_log[0], vecs[k].exp_stb);
      if (!vecs[k].rw && vecs[k].nbits >= 16) check($sformatf("vec%0d read", k), rd, vecs[k].exp_rd);
      check($sformatf("vec%0d oe timing", k), oe_err, 0);
      check($sformatf("vec%0d oe idle", k), cipo_oe, 1'b0);
    end

    // sclk activity with ncs high must be ignored.
    stb_log.delete();
    for (int i = 0; i < 6; i++) begin
      copi = 1'($urandom);
      #HALF sclk = 1'b1;
      #HALF sclk = 1'b0;
    end
    #60;
    check("idle sclk regs", regs_flat, m_flat());
    check("idle sclk strobes", stb_log.size(), 0);

    // Reset in the middle of a write frame, then a clean write.
    begin
      logic [17:0] w;
      w = {1'b1, 7'h00, 8'h5A, 2'b00};
      ncs = 1'b0;
      #HALF;
      for (int i = 0; i < 10; i++) begin
        copi = w[17-i];
        #HALF sclk = 1'b1;
        #HALF sclk = 1'b0;
      end
      rst = 1'b1;
      #30;
      check("mid rst regs", regs_flat, '0);
      check("mid rst cipo_oe", cipo_oe, 1'b0);
      ncs = 1'b1; copi = 1'b0;
      #30 rst = 1'b0;
      #50;
      model_reset();
      stb_log.delete();
      model_frame(1'b1, 7'h00, 8'h81, 16, m_stb, m_rd);
      spi_xfer(1'b1, 7'h00, 8'h81, 16, rd, oe_err);
      check("post rst regs", regs_flat, 40'h00_00_00_00_81);
      #60;
      check("post rst strobe pulses", stb_log.size(), 1);
      if (stb_log.size() > 0) check("post rst strobe", stb_log[0], 5'b00001);
    end

    // Back-to-back writes with one sclk period of ncs high between them.
    stb_log.delete();
    model_frame(1'b1, 7'h00, 8'h11, 16, m_stb, m_rd);
    model_frame(1'b1, 7'h01, 8'h22, 16, m_stb, m_rd);
    spi_xfer(1'b1, 7'h00, 8'h11, 16, rd, oe_err);
    #60;
    spi_xfer(1'b1, 7'h01, 8'h22, 16, rd, oe_err);
    #60;
    check("b2b regs", regs_flat, 40'h00_00_00_22_11);
    check("b2b strobe pulses", stb_log.size(), 2);
    if (stb_log.size() == 2) begin
      check("b2b strobe 0", stb_log[0], 5'b00001);
      check("b2b strobe 1", stb_log[1], 5'b00010);
    end

    // Random frames against the model.
    for (int n = 0; n < 40; n++) begin
      logic rw;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      int nbits, r;
      rw = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      addr = (r < 8) ? AW'(r) : ((r == 8) ? 7'h7F : AW'($urandom));
      data = DW'($urandom);
      r = $urandom_range(0, 7);
      nbits = (r == 0) ? $urandom_range(9, 15) : (r == 1) ? 17 : (r == 2) ? 18 : 16;
      stb_log.delete();
      model_frame(rw, addr, data, nbits, m_stb, m_rd);
      spi_xfer(rw, addr, data, nbits, rd, oe_err);
      check($sformatf("rnd%0d regs", n), regs_flat, m_flat());
      #60;
      check($sformatf("rnd%0d strobe pulses", n), stb_log.size(), (m_stb != '0) ? 1 : 0);
      if (stb_log.size() > 0) check($sformatf("rnd%0d strobe", n), stb_log[0], m_stb);
      if (!rw && nbits >= 16) check($sformatf("rnd%0d read a=%0h", n, addr), rd, m_rd);
      check($sformatf("rnd%0d oe timing", n), oe_err, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
